// File: rtl/uart_rx_fifo.sv
// UART receiver with majority-vote oversampling, runtime parity/stop-bit
// selection, break detection and a first-word-fall-through receive FIFO.
module uart_rx_fifo #(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 16,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_rx,
    input  logic [DIV_W-1:0]         i_clk_div,
    input  logic                     i_parity_en,
    input  logic                     i_parity_odd,
    input  logic                     i_two_stop,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_parity_err,
    output logic                     o_frame_err,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_overrun,
    input  logic                     i_clr_overrun,
    output logic                     o_break
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_W);
    localparam int EW = DATA_W + 2;

    localparam logic [SW-1:0] SAMP_A    = SW'(OVERSAMPLE/2 - 1);
    localparam logic [SW-1:0] SAMP_B    = SW'(OVERSAMPLE/2);
    localparam logic [SW-1:0] SAMP_C    = SW'(OVERSAMPLE/2 + 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } state_t;

    state_t state_q, state_d;

    logic              rxMeta_q, rxSync_q, rxPrev_q;
    logic [DIV_W-1:0]  divCnt_q;
    logic [DIV_W-1:0]  divEff;
    logic [SW-1:0]     sampleCnt_q;
    logic              s0_q, s1_q, bitVote_q;
    logic [DATA_W-1:0] shift_q;
    logic [BW-1:0]     bitCnt_q;
    logic              parBit_q, frameErr_q;
    logic              parEn_q, parOdd_q, twoStop_q;
    logic              armed_q;

    logic tick, voteTick, bitEnd, vote, startDet;
    logic push, brk, stop1Low, frameErrNow, parityErr;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wrPtr_q, rdPtr_q;
    logic [CW-1:0] count_q;
    logic          overrun_q;
    logic          pop, full, accept, ovfSet;
    logic [EW-1:0] headWord;

    assign divEff   = (i_clk_div == '0) ? DIV_W'(1) : i_clk_div;
    assign tick     = (divCnt_q >= divEff - DIV_W'(1));
    assign voteTick = tick && (sampleCnt_q == SAMP_C);
    assign bitEnd   = tick && (sampleCnt_q == SAMP_LAST);
    assign vote     = (s0_q & s1_q) | (s0_q & rxSync_q) | (s1_q & rxSync_q);
    assign startDet = (state_q == IDLE) && armed_q && rxPrev_q && !rxSync_q;

    assign stop1Low    = (state_q == STOP1) ? !vote : frameErr_q;
    assign frameErrNow = stop1Low | ((state_q == STOP2) & !vote);
    assign parityErr   = parEn_q & (((^shift_q) ^ parBit_q) != parOdd_q);
    assign brk         = push & (shift_q == '0) & !parBit_q & stop1Low;

    // Bring the asynchronous line into the clock domain and keep one cycle of history for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
            rxPrev_q <= 1'b1;
        end else begin
            rxMeta_q <= i_rx;
            rxSync_q <= rxMeta_q;
            rxPrev_q <= rxSync_q;
        end
    end

    // Receiver state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Bit-level sequencing; the word is pushed at the mid-bit vote of the last stop bit.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (startDet) state_d = START;
            end
            START: begin
                if (bitEnd) state_d = bitVote_q ? IDLE : DATA;
            end
            DATA: begin
                if (bitEnd && (bitCnt_q == BIT_LAST)) state_d = parEn_q ? PARITY : STOP1;
            end
            PARITY: begin
                if (bitEnd) state_d = STOP1;
            end
            STOP1: begin
                if (voteTick && !twoStop_q) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end else if (bitEnd) begin
                    state_d = STOP2;
                end
            end
            STOP2: begin
                if (voteTick) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Tick generation, sample capture, data shifting and per-frame config latching.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            divCnt_q    <= '0;
            sampleCnt_q <= '0;
            s0_q        <= 1'b1;
            s1_q        <= 1'b1;
            bitVote_q   <= 1'b1;
            shift_q     <= '0;
            bitCnt_q    <= '0;
            parBit_q    <= 1'b0;
            frameErr_q  <= 1'b0;
            parEn_q     <= 1'b0;
            parOdd_q    <= 1'b0;
            twoStop_q   <= 1'b0;
            armed_q     <= 1'b1;
        end else if (startDet) begin
            divCnt_q    <= '0;
            sampleCnt_q <= '0;
            shift_q     <= '0;
            bitCnt_q    <= '0;
            parBit_q    <= 1'b0;
            frameErr_q  <= 1'b0;
            parEn_q     <= i_parity_en;
            parOdd_q    <= i_parity_odd;
            twoStop_q   <= i_two_stop;
        end else begin
            if (tick) begin
                divCnt_q    <= '0;
                sampleCnt_q <= (sampleCnt_q == SAMP_LAST) ? '0 : sampleCnt_q + SW'(1);
            end else begin
                divCnt_q <= divCnt_q + DIV_W'(1);
            end
            if (tick && (sampleCnt_q == SAMP_A)) s0_q <= rxSync_q;
            if (tick && (sampleCnt_q == SAMP_B)) s1_q <= rxSync_q;
            if (voteTick) bitVote_q <= vote;
            if ((state_q == DATA) && voteTick) shift_q <= {vote, shift_q[DATA_W-1:1]};
            if ((state_q == DATA) && bitEnd) bitCnt_q <= bitCnt_q + BW'(1);
            if ((state_q == PARITY) && voteTick) parBit_q <= vote;
            if ((state_q == STOP1) && voteTick) frameErr_q <= !vote;
            if (brk) begin
                armed_q <= 1'b0;
            end else if ((state_q == IDLE) && tick && rxSync_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign pop    = o_valid & i_ready;
    assign full   = (count_q == CW'(DEPTH));
    assign accept = push & (!full | pop);
    assign ovfSet = push & full & !pop;

    // FIFO pointers, occupancy and the sticky overrun flag; a fresh overrun beats a clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (accept) wrPtr_q <= wrPtr_q + AW'(1);
            if (pop) rdPtr_q <= rdPtr_q + AW'(1);
            case ({accept, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (ovfSet) begin
                overrun_q <= 1'b1;
            end else if (i_clr_overrun) begin
                overrun_q <= 1'b0;
            end
        end
    end

    // Storage array is not reset; outputs are masked while the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (accept) mem[wrPtr_q] <= {frameErrNow, parityErr, shift_q};
    end

    assign headWord     = mem[rdPtr_q];
    assign o_valid      = (count_q != '0);
    assign o_data       = o_valid ? headWord[DATA_W-1:0] : '0;
    assign o_parity_err = o_valid ? headWord[DATA_W] : 1'b0;
    assign o_frame_err  = o_valid ? headWord[DATA_W+1] : 1'b0;
    assign o_count      = count_q;
    assign o_full       = full;
    assign o_overrun    = overrun_q;
    assign o_break      = brk;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo: 4-entry FIFO, 16x oversampling, divisor 4.
module tb_uart_rx_fifo;

    localparam int BIT = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx;
    logic [15:0] clkDiv;
    logic        parityEn, parityOdd, twoStop;
    logic [7:0]  data;
    logic        parityErr, frameErr, valid, ready;
    logic [2:0]  count;
    logic        full, overrun, clrOverrun, brk;

    int testsRun = 0;
    int failures = 0;
    int breakCount = 0;
    int breakBase;
    logic breakSeen;

    uart_rx_fifo #(
        .DATA_W(8),
        .DEPTH(4),
        .OVERSAMPLE(16),
        .DIV_W(16)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_rx(rx),
        .i_clk_div(clkDiv),
        .i_parity_en(parityEn),
        .i_parity_odd(parityOdd),
        .i_two_stop(twoStop),
        .o_data(data),
        .o_parity_err(parityErr),
        .o_frame_err(frameErr),
        .o_valid(valid),
        .i_ready(ready),
        .o_count(count),
        .o_full(full),
        .o_overrun(overrun),
        .i_clr_overrun(clrOverrun),
        .o_break(brk)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Count break pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (brk) breakCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] word, input logic withParity, input logic parBit,
                                 input logic stop1, input logic withStop2, input logic stop2);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = word[i];
            repeat (BIT) @(negedge clk);
        end
        if (withParity) begin
            rx = parBit;
            repeat (BIT) @(negedge clk);
        end
        rx = stop1;
        repeat (BIT) @(negedge clk);
        if (withStop2) begin
            rx = stop2;
            repeat (BIT) @(negedge clk);
        end
        rx = 1'b1;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic popWord(input string tag, input logic [7:0] expected);
        checkOutput(tag, {24'h0, data}, {24'h0, expected});
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        rx         = 1'b1;
        clkDiv     = 16'd4;
        parityEn   = 1'b0;
        parityOdd  = 1'b0;
        twoStop    = 1'b0;
        ready      = 1'b0;
        clrOverrun = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("reset_valid", valid, 0);
        checkOutput("reset_count", count, 0);
        checkOutput("reset_full", full, 0);
        checkOutput("reset_data", data, 0);
        checkOutput("reset_overrun", overrun, 0);
        checkOutput("reset_break", brk, 0);
        rst_n = 1'b1;
        repeat (2 * BIT) @(negedge clk);

        applyStimulus(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("a5_valid", valid, 1);
        checkOutput("a5_data", data, 8'hA5);
        checkOutput("a5_parity_err", parityErr, 0);
        checkOutput("a5_frame_err", frameErr, 0);
        checkOutput("a5_count", count, 1);
        popWord("a5_pop", 8'hA5);
        checkOutput("a5_valid_after_pop", valid, 0);
        checkOutput("a5_count_after_pop", count, 0);

        parityEn  = 1'b1;
        parityOdd = 1'b0;
        applyStimulus(8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("even_parity_err", parityErr, 1);
        checkOutput("even_frame_err", frameErr, 0);
        popWord("even_data", 8'h03);
        parityOdd = 1'b1;
        applyStimulus(8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("odd_parity_err", parityErr, 0);
        popWord("odd_data", 8'h03);

        parityEn  = 1'b0;
        twoStop   = 1'b1;
        breakBase = breakCount;
        applyStimulus(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("stop2_frame_err", frameErr, 1);
        checkOutput("stop2_parity_err", parityErr, 0);
        checkOutput("stop2_no_break", breakCount - breakBase, 0);
        popWord("stop2_data", 8'h5A);
        twoStop = 1'b0;

        rx = 1'b0;
        repeat (8) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        checkOutput("glitch_no_entry", valid, 0);

        applyStimulus(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(8'h44, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("fill_full", full, 1);
        checkOutput("fill_overrun", overrun, 0);
        applyStimulus(8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("ovf_overrun", overrun, 1);
        checkOutput("ovf_count", count, 4);
        popWord("ovf_pop0", 8'h11);
        popWord("ovf_pop1", 8'h22);
        popWord("ovf_pop2", 8'h33);
        popWord("ovf_pop3", 8'h44);
        checkOutput("ovf_drained", valid, 0);
        clrOverrun = 1'b1;
        @(negedge clk);
        clrOverrun = 1'b0;
        checkOutput("ovf_cleared", overrun, 0);

        applyStimulus(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(8'h44, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        rx = 1'b0;
        repeat (9 * BIT) @(negedge clk);
        breakSeen = 1'b0;
        for (int i = 0; i < 2 * BIT; i++) begin
            if (!breakSeen && brk) begin
                breakSeen = 1'b1;
                ready = 1'b1;
                @(negedge clk);
                ready = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        checkOutput("concurrent_break_seen", breakSeen, 1);
        checkOutput("concurrent_no_overrun", overrun, 0);
        checkOutput("concurrent_count", count, 4);
        popWord("concurrent_pop0", 8'h22);
        popWord("concurrent_pop1", 8'h33);
        popWord("concurrent_pop2", 8'h44);
        checkOutput("concurrent_tail_frame_err", frameErr, 1);
        popWord("concurrent_tail_data", 8'h00);

        breakBase = breakCount;
        rx = 1'b0;
        repeat (30 * BIT) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        checkOutput("break_pulses", breakCount - breakBase, 1);
        checkOutput("break_count", count, 1);
        checkOutput("break_frame_err", frameErr, 1);
        checkOutput("break_parity_err", parityErr, 0);
        popWord("break_data", 8'h00);
        applyStimulus(8'h7E, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("after_break_count", count, 1);
        checkOutput("after_break_frame_err", frameErr, 0);
        checkOutput("after_break_parity_err", parityErr, 0);
        popWord("after_break_data", 8'h7E);

        applyStimulus(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("pre_reset_count", count, 1);
        parityEn = 1'b1;
        rx = 1'b0;
        repeat (3 * BIT) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_valid", valid, 0);
        checkOutput("midreset_count", count, 0);
        checkOutput("midreset_data", data, 0);
        checkOutput("midreset_overrun", overrun, 0);
        repeat (3) @(negedge clk);
        rx    = 1'b1;
        rst_n = 1'b1;
        repeat (20 * BIT) @(negedge clk);
        checkOutput("postreset_valid", valid, 0);
        checkOutput("postreset_count", count, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver with a buffered output path, succeeding the fixed-format receive path in uart_top. It oversamples i_rx with majority voting and supports a runtime-selected parity mode and 1 or 2 stop bits. It detects framing, parity, overrun and break conditions, and stores received words with per-word error tags in a first-word-fall-through FIFO drained by a valid/ready handshake.

Parameters:
DATA_W, 8, data bits per frame (5..9)
DEPTH, 16, FIFO entries (power of 2, >=2)
OVERSAMPLE, 16, sample ticks per bit (even, >=8)
DIV_W, 16, width of the baud divisor input

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_rx  in  1  serial input, asynchronous to i_clk
i_clk_div  in  DIV_W  i_clk cycles per oversample tick; 0 is treated as 1
i_parity_en  in  1  parity bit present after the data bits
i_parity_odd  in  1  1 = odd parity, 0 = even parity
i_two_stop  in  1  1 = two stop bits
o_data  out  DATA_W  word at the FIFO head
o_parity_err  out  1  parity error tag of the head word
o_frame_err  out  1  framing error tag of the head word
o_valid  out  1  FIFO not empty
i_ready  in  1  pop the head when o_valid is also high
o_count  out  $clog2(DEPTH)+1  FIFO occupancy
o_full  out  1  occupancy == DEPTH
o_overrun  out  1  sticky: a word was dropped because the FIFO was full
i_clr_overrun  in  1  clear o_overrun
o_break  out  1  one-cycle pulse on break detection

Behaviour:
- Reset (async assert, synchronous release): FIFO empty; o_valid=0, o_count=0, o_full=0, o_data=0, both error tags 0, o_overrun=0, o_break=0; FSM in IDLE; i_rx synchroniser and its history reset to 1.
- i_rx passes through a 2-FF synchroniser. Tick counter: one tick every max(i_clk_div,1) cycles. The counter restarts on start detection.
- Majority vote: bit value = majority of the samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of each bit period.
- Config: i_parity_en, i_parity_odd and i_two_stop are latched at start detection. Changes mid-frame have no effect on the current frame.
- FSM states and transitions:
  - IDLE: wait for synced rx 1->0, then go to START. A low line on entry (after a break) is ignored until rx has been high for at least one tick.
  - START: at the end of the bit period, a voted 1 is a false start; return to IDLE with no FIFO write. Otherwise go to DATA.
  - DATA: receive DATA_W bits, LSB first.
  - PARITY: only entered when parity is enabled. parity_err = XOR(data, parity bit) != i_parity_odd.
  - STOP1: at the voted sample (mid-bit), a 0 sets frame_err.
  - STOP2: only entered when i_two_stop is set. A 0 sets frame_err.
- Frame completion: at the mid-bit sample of the final stop bit, push {frame_err, parity_err, data} and return to IDLE. The receiver does not wait out the remaining half stop bit.
- Break: data all 0, parity bit (if enabled) 0, and the first stop bit 0.
  - o_break pulses for 1 cycle in the push cycle.
  - The entry is pushed with frame_err=1 and data=0. parity_err is computed normally.
  - IDLE then requires a high line before the next start is accepted.
- FIFO:
  - First-word-fall-through. A push in cycle N gives o_valid=1 with the word on the outputs at N+1.
  - Pop occurs when o_valid && i_ready. The next word appears the following cycle.
  - Push when full and no pop: the word is dropped, contents are unchanged, and o_overrun is set.
  - Push and pop in the same cycle when full: both are accepted; count is unchanged and no overrun.
  - Push and pop in the same cycle when count==1: the new word is the head at N+1.
  - Pointers wrap modulo DEPTH.
- o_overrun: cleared by i_clr_overrun. A new overrun in the same cycle as the clear wins, so o_overrun stays 1.
- Reset mid-frame or with the FIFO non-empty: the partial frame and all stored words are discarded.

Test Plan:
- Reset while an 8E1 frame is in flight -> all outputs at reset values, o_count=0. Line idle for 2 frames afterwards -> no entry.
- i_clk_div=4, 8N1, send 0xA5 -> o_valid rises, o_data=0xA5, both error tags 0, o_count=1. Assert i_ready for 1 cycle -> o_valid=0, o_count=0.
- 8E1, send 0x03 with parity bit 1 -> entry data=0x03, parity_err=1, frame_err=0. Repeat with parity odd and bit 1 -> parity_err=0.
- Stop bit driven 0 for 0x5A (8N2, second stop low) -> frame_err=1, data=0x5A, no o_break. A 2-tick low glitch in IDLE -> no entry, FSM back in IDLE.
- DEPTH=4, send 5 bytes 0x11..0x55 without pop -> o_full=1, o_overrun=1, pops return 0x11,0x22,0x33,0x44. i_clr_overrun -> o_overrun=0. Push concurrent with pop while full -> no overrun.
- Hold i_rx low for 3 frame times -> exactly one o_break pulse and one entry (data=0, frame_err=1). Release high, then send 0x7E -> 0x7E received cleanly.
